// File: rtl/wb_trace_buffer.sv
// Writeback trace recorder: logs {cycle, pc, rd, wdata} of RF writes into a FWFT FIFO.
// Optional PC trigger gating is compiled in with `define WB_TRACE_TRIG_EN.
module wb_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 16,
  parameter int CYCW  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     wb_we,
  input  logic [REGW-1:0]          wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [XLEN-1:0]          wb_pc,
`ifdef WB_TRACE_TRIG_EN
  input  logic [XLEN-1:0]          trig_pc,
  output logic                     triggered,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYCW-1:0]          out_cycle,
  output logic [XLEN-1:0]          out_pc,
  output logic [REGW-1:0]          out_rd,
  output logic [XLEN-1:0]          out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              overflow_cnt
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef struct packed {
    logic [CYCW-1:0] cyc;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [15:0]     ovf_q, ovf_d;
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic            trig_q, trig_d;

  logic   qual, push_req, empty, full, pop, push, drop, mem_we;
  entry_t wr_entry, head;

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    qual     = en & wb_we & (wb_rd != '0);
`ifdef WB_TRACE_TRIG_EN
    // The matching event both arms the trigger and is itself captured.
    push_req = qual & (trig_q | (wb_pc == trig_pc));
    trig_d   = clear ? 1'b0 : (trig_q | (qual & (wb_pc == trig_pc)));
`else
    push_req = qual;
    trig_d   = 1'b0;
`endif
    empty    = (cnt_q == '0);
    full     = (cnt_q == CNTW'(DEPTH));
    pop      = ~empty & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    wr_entry = '{cyc: cyc_q, pc: wb_pc, rd: wb_rd, data: wb_data};
    cyc_d    = cyc_q + CYCW'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = '0;
    end else begin
      mem_we = push;
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNTW'(1);
        2'b01:   cnt_d = cnt_q - CNTW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= '0;
      cyc_q    <= '0;
      trig_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
      trig_q   <= trig_d;
    end
  end

  // NOTE: the storage array is not reset; stale contents are never visible because outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = ~empty;
    out_cycle = out_valid ? head.cyc  : '0;
    out_pc    = out_valid ? head.pc   : '0;
    out_rd    = out_valid ? head.rd   : '0;
    out_data  = out_valid ? head.data : '0;
  end

  assign count        = cnt_q;
  assign overflow_cnt = ovf_q;
`ifdef WB_TRACE_TRIG_EN
  assign triggered    = trig_q;
`endif

endmodule
